control_iluminacion: RTL and testbench

Multi-zone lighting scheduler for the domotic house. It takes per-zone motion signals and the day/night flag, and latches motion requests per zone. At night it grants lights under a global power budget, using round-robin arbitration, and times each lit zone out after a retriggerable hold period. It drives the zone bulbs and reports latched motion and the number of lights currently lit.

---
 rtl/control_iluminacion.sv | 128 ++++++++++++
 tb/tb_control_iluminacion.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/control_iluminacion.sv
// Multi-zone lighting scheduler: latches per-zone motion at night, grants
// lights round-robin under a global power budget and times each lit zone out
// after a retriggerable hold period.
module control_iluminacion #(
  parameter int unsigned NZ     = 4,
  parameter int unsigned HOLD   = 16,
  parameter int unsigned MAX_ON = 2,
  parameter int unsigned TW     = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          startIlu,
  input  logic          tiempo,
  input  logic [NZ-1:0] signD,
  output logic [NZ-1:0] wasTMove,
  output logic [NZ-1:0] bulb,
  output logic [3:0]    on_count
);

  localparam int unsigned PW       = (NZ > 1) ? $clog2(NZ) : 1;
  localparam logic [TW-1:0] HOLD_C = TW'(HOLD);
  localparam logic [3:0] MAX_ON_C  = 4'(MAX_ON);
  localparam logic [PW-1:0] LAST_Z = PW'(NZ - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ON   = 2'd2
  } zone_state_t;

  zone_state_t   state_q [NZ];
  zone_state_t   state_d [NZ];
  logic [TW-1:0] timer_q [NZ];
  logic [TW-1:0] timer_d [NZ];
  logic [PW-1:0] ptr_q, ptr_d;

  logic          grant_vld;
  logic [PW-1:0] grant_idx;

  logic [NZ-1:0] bulb_d;
  logic [NZ-1:0] wtm_d;
  logic [3:0]    cnt_d;

  // Round-robin arbiter: first WAIT zone at or after the pointer, budget permitting.
  always_comb begin
    logic [PW-1:0] cand;
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    if (tiempo && (on_count < MAX_ON_C)) begin
      for (int unsigned k = 0; k < NZ; k++) begin
        cand = PW'((32'(ptr_q) + k) % NZ);
        if (!grant_vld && (state_q[cand] == WAIT)) begin
          grant_vld = 1'b1;
          grant_idx = cand;
        end
      end
    end
  end

  // Per-zone next state, hold timers, pointer update and derived outputs.
  always_comb begin
    ptr_d  = ptr_q;
    bulb_d = '0;
    wtm_d  = '0;
    cnt_d  = '0;
    for (int unsigned i = 0; i < NZ; i++) begin
      state_d[i] = state_q[i];
      timer_d[i] = timer_q[i];
      if (!tiempo) begin
        // Day wins over any motion arriving on the same edge.
        state_d[i] = IDLE;
        timer_d[i] = '0;
      end else begin
        unique case (state_q[i])
          IDLE: begin
            if (startIlu && signD[i]) state_d[i] = WAIT;
          end
          WAIT: begin
            if (grant_vld && (grant_idx == PW'(i))) begin
              state_d[i] = ON;
              timer_d[i] = HOLD_C;
            end
          end
          ON: begin
            // Loading HOLD (not HOLD-1) keeps the bulb lit for HOLD+1 cycles
            // after the last motion, counting the expiry check at zero.
            if (signD[i])                 timer_d[i] = HOLD_C;
            else if (timer_q[i] != '0)    timer_d[i] = timer_q[i] - 1'b1;
            else                          state_d[i] = IDLE;
          end
          default: begin
            state_d[i] = IDLE;
            timer_d[i] = '0;
          end
        endcase
      end
      bulb_d[i] = (state_d[i] == ON);
      wtm_d[i]  = (state_d[i] == WAIT) || (state_d[i] == ON);
      cnt_d     = cnt_d + {3'b000, bulb_d[i]};
    end
    if (grant_vld) ptr_d = (grant_idx == LAST_Z) ? '0 : grant_idx + 1'b1;
  end

  // State, timers, pointer and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NZ; i++) begin
        state_q[i] <= IDLE;
        timer_q[i] <= '0;
      end
      ptr_q    <= '0;
      bulb     <= '0;
      wasTMove <= '0;
      on_count <= '0;
    end else begin
      for (int unsigned i = 0; i < NZ; i++) begin
        state_q[i] <= state_d[i];
        timer_q[i] <= timer_d[i];
      end
      ptr_q    <= ptr_d;
      bulb     <= bulb_d;
      wasTMove <= wtm_d;
      on_count <= cnt_d;
    end
  end

endmodule

// File: tb/tb_control_iluminacion.sv
// Directed testbench for control_iluminacion (NZ=4, HOLD=16, MAX_ON=2).
module tb_control_iluminacion;

  localparam int unsigned NZ = 4;

  logic          clk;
  logic          reset;
  logic          startIlu;
  logic          tiempo;
  logic [NZ-1:0] signD;
  logic [NZ-1:0] wasTMove;
  logic [NZ-1:0] bulb;
  logic [3:0]    on_count;

  int compared;
  int mismatched;

  control_iluminacion #(
    .NZ(4),
    .HOLD(16),
    .MAX_ON(2),
    .TW(5)
  ) dut (
    .clk(clk),
    .reset(reset),
    .startIlu(startIlu),
    .tiempo(tiempo),
    .signD(signD),
    .wasTMove(wasTMove),
    .bulb(bulb),
    .on_count(on_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle past it before sampling.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; tiempo = 1'b1; startIlu = 1'b1; signD = 4'b1111;
    tick();
    compared++;
    if ({wasTMove, bulb, on_count} !== {4'b0000, 4'b0000, 4'd0}) begin
      mismatched++;
      $display("FAIL reset: got w=%b b=%b c=%0d, expected w=0000 b=0000 c=0", wasTMove, bulb, on_count);
    end
    reset = 1'b0;
  endtask

  task automatic test_day;
    tiempo = 1'b0; startIlu = 1'b1; signD = 4'b1111;
    for (int e = 1; e <= 10; e++) begin
      tick();
      compared++;
      if ({wasTMove, bulb, on_count} !== {4'b0000, 4'b0000, 4'd0}) begin
        mismatched++;
        $display("FAIL day_%0d: got w=%b b=%b c=%0d, expected w=0000 b=0000 c=0", e, wasTMove, bulb, on_count);
      end
    end
    signD = 4'b0000;
  endtask

  task automatic test_single_pulse;
    logic [3:0] eb;
    tiempo = 1'b1; startIlu = 1'b1; signD = 4'b0001;
    tick();
    compared++;
    if ({wasTMove, bulb, on_count} !== {4'b0001, 4'b0000, 4'd0}) begin
      mismatched++;
      $display("FAIL single_wait: got w=%b b=%b c=%0d, expected w=0001 b=0000 c=0", wasTMove, bulb, on_count);
    end
    signD = 4'b0000;
    for (int e = 1; e <= 18; e++) begin
      tick();
      eb = (e <= 17) ? 4'b0001 : 4'b0000;
      compared++;
      if ({wasTMove, bulb, on_count} !== {eb, eb, (e <= 17) ? 4'd1 : 4'd0}) begin
        mismatched++;
        $display("FAIL single_k+%0d: got w=%b b=%b c=%0d, expected w=%b b=%b", e, wasTMove, bulb, on_count, eb, eb);
      end
    end
  endtask

  task automatic test_retrigger;
    logic [3:0] eb;
    reset = 1'b1; signD = 4'b0000; tick(); reset = 1'b0;
    tiempo = 1'b1; startIlu = 1'b1; signD = 4'b0001;
    tick();
    for (int e = 1; e <= 27; e++) begin
      signD = (e == 10) ? 4'b0001 : 4'b0000;
      tick();
      eb = (e <= 26) ? 4'b0001 : 4'b0000;
      compared++;
      if ({wasTMove, bulb} !== {eb, eb}) begin
        mismatched++;
        $display("FAIL retrigger_k+%0d: got w=%b b=%b, expected w=%b b=%b", e, wasTMove, bulb, eb, eb);
      end
    end
    signD = 4'b0000;
  endtask

  task automatic test_budget_round_robin;
    logic [3:0] eb, ew, ec;
    reset = 1'b1; signD = 4'b0000; tick(); reset = 1'b0;
    tiempo = 1'b1; startIlu = 1'b1; signD = 4'b0111;
    tick();
    compared++;
    if ({wasTMove, bulb, on_count} !== {4'b0111, 4'b0000, 4'd0}) begin
      mismatched++;
      $display("FAIL budget_wait: got w=%b b=%b c=%0d, expected w=0111 b=0000 c=0", wasTMove, bulb, on_count);
    end
    signD = 4'b0000;
    for (int e = 1; e <= 19; e++) begin
      tick();
      ew = 4'b0111; eb = 4'b0011; ec = 4'd2;
      if (e == 1)  begin eb = 4'b0001; ec = 4'd1; end
      if (e == 18) begin ew = 4'b0110; eb = 4'b0010; ec = 4'd1; end
      if (e == 19) begin ew = 4'b0100; eb = 4'b0100; ec = 4'd1; end
      compared++;
      if ({wasTMove, bulb, on_count} !== {ew, eb, ec}) begin
        mismatched++;
        $display("FAIL budget_k+%0d: got w=%b b=%b c=%0d, expected w=%b b=%b c=%0d", e, wasTMove, bulb, on_count, ew, eb, ec);
      end
    end
  endtask

  task automatic test_day_override;
    reset = 1'b1; signD = 4'b0000; tick(); reset = 1'b0;
    tiempo = 1'b1; startIlu = 1'b1; signD = 4'b0111;
    tick();
    signD = 4'b0000;
    tick(); tick();
    compared++;
    if ({wasTMove, bulb, on_count} !== {4'b0111, 4'b0011, 4'd2}) begin
      mismatched++;
      $display("FAIL override_pre: got w=%b b=%b c=%0d, expected w=0111 b=0011 c=2", wasTMove, bulb, on_count);
    end
    tiempo = 1'b0; signD = 4'b1111;
    tick();
    compared++;
    if ({wasTMove, bulb, on_count} !== {4'b0000, 4'b0000, 4'd0}) begin
      mismatched++;
      $display("FAIL override_day: got w=%b b=%b c=%0d, expected all 0", wasTMove, bulb, on_count);
    end
    tiempo = 1'b1; signD = 4'b0000;
    for (int e = 1; e <= 5; e++) begin
      tick();
      compared++;
      if ({wasTMove, bulb, on_count} !== {4'b0000, 4'b0000, 4'd0}) begin
        mismatched++;
        $display("FAIL override_night_%0d: got w=%b b=%b c=%0d, expected all 0", e, wasTMove, bulb, on_count);
      end
    end
  endtask

  task automatic test_startilu_and_reset;
    logic [3:0] eb;
    reset = 1'b1; signD = 4'b0000; tick(); reset = 1'b0;
    tiempo = 1'b1; startIlu = 1'b1; signD = 4'b0011;
    tick();
    signD = 4'b0000;
    tick(); tick();
    startIlu = 1'b0; signD = 4'b1000;
    tick();
    compared++;
    if ({wasTMove, bulb, on_count} !== {4'b0011, 4'b0011, 4'd2}) begin
      mismatched++;
      $display("FAIL nostart_zone3: got w=%b b=%b c=%0d, expected w=0011 b=0011 c=2", wasTMove, bulb, on_count);
    end
    signD = 4'b0001;
    tick();
    signD = 4'b0000;
    for (int e = 5; e <= 21; e++) begin
      tick();
      eb = (e <= 18) ? 4'b0011 : ((e <= 20) ? 4'b0001 : 4'b0000);
      compared++;
      if ({wasTMove, bulb} !== {eb, eb}) begin
        mismatched++;
        $display("FAIL nostart_k+%0d: got w=%b b=%b, expected w=%b b=%b", e, wasTMove, bulb, eb, eb);
      end
    end
    startIlu = 1'b1; signD = 4'b0001;
    tick();
    signD = 4'b0000;
    tick(); tick(); tick();
    compared++;
    if ({wasTMove, bulb, on_count} !== {4'b0001, 4'b0001, 4'd1}) begin
      mismatched++;
      $display("FAIL midhold_pre: got w=%b b=%b c=%0d, expected w=0001 b=0001 c=1", wasTMove, bulb, on_count);
    end
    reset = 1'b1; signD = 4'b1111;
    tick();
    compared++;
    if ({wasTMove, bulb, on_count} !== {4'b0000, 4'b0000, 4'd0}) begin
      mismatched++;
      $display("FAIL midhold_reset: got w=%b b=%b c=%0d, expected all 0", wasTMove, bulb, on_count);
    end
    reset = 1'b0; signD = 4'b0000;
    tick();
    compared++;
    if ({wasTMove, bulb, on_count} !== {4'b0000, 4'b0000, 4'd0}) begin
      mismatched++;
      $display("FAIL after_reset: got w=%b b=%b c=%0d, expected all 0", wasTMove, bulb, on_count);
    end
  endtask

  initial begin
    compared = 0;
    mismatched = 0;
    reset = 1'b1; startIlu = 1'b0; tiempo = 1'b0; signD = 4'b0000;
    test_reset();
    test_day();
    test_single_pulse();
    test_retrigger();
    test_budget_round_robin();
    test_day_override();
    test_startilu_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
